// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic [WIDTH+1:0] w_next;
  logic             w_unused;

  assign w_shift  = {i_rem, i_bit};
  assign w_diff   = w_shift - {2'b00, i_div};
  assign o_q      = (w_shift >= {2'b00, i_div});
  assign w_next   = o_q ? w_diff : w_shift;
  assign o_rem    = w_next[WIDTH:0];
  // Remainder stays below the divisor, so the top bit is always zero.
  assign w_unused = w_next[WIDTH+1];

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed/unsigned divider with start/ready/valid handshake and Z/N/C/V flags.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sign,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_z,
  output logic             o_n,
  output logic             o_c,
  output logic             o_v
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic             r_sign, r_qneg, r_rneg, r_zdiv, r_ovf;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_sr;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_valid, r_z, r_n, r_c, r_v;
  logic [WIDTH-1:0] r_q, r_r;

  logic [WIDTH:0]   w_rem_nxt;
  logic             w_qbit;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_q_fix, w_r_fix;

  // MIN negates to itself, which is exactly its unsigned magnitude.
  assign w_dvd_mag = (r_sign && r_dvd[WIDTH-1]) ? -r_dvd : r_dvd;
  assign w_dvs_mag = (r_sign && r_dvs[WIDTH-1]) ? -r_dvs : r_dvs;
  assign w_q_fix   = r_qneg ? -r_sr : r_sr;
  assign w_r_fix   = r_rneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_bit (r_sr[WIDTH-1]),
    .i_div (r_dvs),
    .o_rem (w_rem_nxt),
    .o_q   (w_qbit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_zdiv  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_sr    <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_dvd   <= i_dividend;
            r_dvs   <= i_divisor;
            r_sign  <= i_sign;
            r_zdiv  <= 1'b0;
            r_state <= PREP;
          end
        end
        PREP: begin
          r_qneg <= r_sign & (r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1]);
          r_rneg <= r_sign & r_dvd[WIDTH-1];
          r_ovf  <= r_sign && (r_dvd == MIN_VAL) && (&r_dvs);
          if (r_dvs == '0) begin
            r_zdiv  <= 1'b1;
            r_state <= FIX;
          end else begin
            r_rem   <= '0;
            r_sr    <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Dividend bits leave the MSB while quotient bits enter the LSB.
          r_rem <= w_rem_nxt;
          r_sr  <= {r_sr[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          if (r_zdiv) begin
            r_q <= '1;
            r_r <= r_dvd;
            r_z <= 1'b0;
            r_n <= r_sign;
            r_c <= 1'b1;
            r_v <= 1'b1;
          end else begin
            r_q <= w_q_fix;
            r_r <= w_r_fix;
            r_z <= (w_q_fix == '0);
            r_n <= r_sign & w_q_fix[WIDTH-1];
            r_c <= 1'b0;
            r_v <= r_ovf;
          end
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready     = (r_state == IDLE);
  assign o_valid     = r_valid;
  assign o_quotient  = r_q;
  assign o_remainder = r_r;
  assign o_z         = r_z;
  assign o_n         = r_n;
  assign o_c         = r_c;
  assign o_v         = r_v;

endmodule
